// File: rtl/diag_matrix_builder.sv
// Builds a ROWS x COLS matrix from a stream of diagonal elements placed on diagonal k.
// The completed frame is held on a registered unpacked array until the consumer takes it.
module diag_matrix_builder #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned OFF_W     = $clog2(ROWS + COLS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [OFF_W-1:0]     diag_offset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic        [BIT_WIDTH-1:0] in_data,
  output logic        [BIT_WIDTH-1:0] out [ROWS-1:0][COLS-1:0],
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned IW = OFF_W + 1;
  localparam logic signed [IW-1:0] ROWS_S = IW'(ROWS);
  localparam logic signed [IW-1:0] COLS_S = IW'(COLS);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  in_ready_q, out_valid_q;
  logic [IW-1:0]         row_q, col_q, cnt_q, len_q;
  logic [BIT_WIDTH-1:0]  out_q [ROWS-1:0][COLS-1:0];

  logic signed [IW-1:0]  k_s, r0_s, c0_s, lim_a_s, lim_b_s, len_s;
  logic                  clear_c, beat_c, last_c;

  // Frame geometry for the offset presented alongside start
  always_comb begin
    k_s = IW'(diag_offset);
    if (k_s[IW-1]) begin
      r0_s    = -k_s;
      c0_s    = '0;
      lim_a_s = ROWS_S + k_s;
      lim_b_s = COLS_S;
    end else begin
      r0_s    = '0;
      c0_s    = k_s;
      lim_a_s = ROWS_S;
      lim_b_s = COLS_S - k_s;
    end
    len_s = (lim_a_s < lim_b_s) ? lim_a_s : lim_b_s;
    if (len_s[IW-1]) begin
      len_s = '0;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d = state_q;
    clear_c = 1'b0;
    beat_c  = 1'b0;
    last_c  = (cnt_q == (len_q - IW'(1)));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          state_d = (len_s == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          beat_c = 1'b1;
          if (last_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they never see the peer's strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == COLLECT);
      out_valid_q <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (clear_c) begin
      row_q <= r0_s;
      col_q <= c0_s;
      cnt_q <= '0;
      len_q <= len_s;
    end else if (beat_c) begin
      row_q <= row_q + IW'(1);
      col_q <= col_q + IW'(1);
      cnt_q <= cnt_q + IW'(1);
    end
  end

  // Each cell loads only when the write pointer lands on it
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        if (rst || clear_c) begin
          out_q[i][j] <= '0;
        end else if (beat_c && (row_q == IW'(i)) && (col_q == IW'(j))) begin
          out_q[i][j] <= in_data;
        end
      end
    end
  end

  assign out       = out_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_diag_matrix_builder.sv
// Scoreboard bench for diag_matrix_builder: an 8x8 and a 4x6 instance, directed frames
// with hand-placed expected matrices, plus handshake, backpressure and reset checks.
module tb_diag_matrix_builder;

  logic clk;
  logic rst;

  logic              start_a, iv_a, ir_a, ov_a, ordy_a;
  logic signed [4:0] off_a;
  logic [3:0]        data_a;
  logic [3:0]        out_a [7:0][7:0];

  logic              start_b, iv_b, ir_b, ov_b, ordy_b;
  logic signed [4:0] off_b;
  logic [3:0]        data_b;
  logic [3:0]        out_b [3:0][5:0];

  logic [255:0] exp_a [$];
  logic [255:0] exp_b [$];
  logic [255:0] ew;
  logic [3:0]   v [8];

  int n_checks;
  int n_pass;

  diag_matrix_builder #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .diag_offset(off_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(data_a),
    .out(out_a), .out_valid(ov_a), .out_ready(ordy_a)
  );

  diag_matrix_builder #(.BIT_WIDTH(4), .ROWS(4), .COLS(6)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .diag_offset(off_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(data_b),
    .out(out_b), .out_valid(ov_b), .out_ready(ordy_b)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] flat_a();
    logic [255:0] f = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        f[(i*8+j)*4 +: 4] = out_a[i][j];
    return f;
  endfunction

  function automatic logic [255:0] flat_b();
    logic [255:0] f = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++)
        f[(i*6+j)*4 +: 4] = out_b[i][j];
    return f;
  endfunction

  function automatic logic ov(input bit b);
    return b ? ov_b : ov_a;
  endfunction

  function automatic logic ir(input bit b);
    return b ? ir_b : ir_a;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, req);
  endtask

  task automatic chk1(input string nm, input logic got, input logic req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %b required %b", nm, got, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit b, input logic st, input logic signed [4:0] k,
                     input logic ivl, input logic [3:0] d);
    if (b) begin
      start_b = st; off_b = k; iv_b = ivl; data_b = d;
    end else begin
      start_a = st; off_a = k; iv_a = ivl; data_a = d;
    end
  endtask

  task automatic put(input bit b, input int i, input int j, input logic [3:0] val);
    ew[(i*(b ? 6 : 8)+j)*4 +: 4] = val;
  endtask

  task automatic push(input bit b);
    if (b) exp_b.push_back(ew);
    else   exp_a.push_back(ew);
  endtask

  // One unstalled frame with out_ready held high
  task automatic run_frame(input bit b, input logic signed [4:0] k,
                           input logic [3:0] vals [8], input int n);
    drv(b, 1'b1, k, 1'b0, 4'h0);
    cyc();
    drv(b, 1'b0, 5'sd0, 1'b0, 4'h0);
    if (n == 0) begin
      chk1("empty_valid", ov(b), 1'b1);
      chk1("empty_ready", ir(b), 1'b0);
    end else begin
      chk1("collect_ready", ir(b), 1'b1);
    end
    for (int i = 0; i < n; i++) begin
      drv(b, 1'b0, 5'sd0, 1'b1, vals[i]);
      cyc();
    end
    drv(b, 1'b0, 5'sd0, 1'b0, 4'h0);
    if (n > 0) begin
      chk1("done_valid", ov(b), 1'b1);
      chk1("done_ready", ir(b), 1'b0);
    end
    cyc();
    chk1("idle_valid", ov(b), 1'b0);
  endtask

  // Monitor: every handshaken frame is compared with the oldest expected one
  always @(negedge clk) begin
    if (ov_a && ordy_a) begin
      if (exp_a.size() == 0) chk1("frame_a_unexpected", 1'b1, 1'b0);
      else chk("frame_a", flat_a(), exp_a.pop_front());
    end
    if (ov_b && ordy_b) begin
      if (exp_b.size() == 0) chk1("frame_b_unexpected", 1'b1, 1'b0);
      else chk("frame_b", flat_b(), exp_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_pass = 0;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    drv(1'b0, 1'b0, 5'sd0, 1'b0, 4'h0);
    drv(1'b1, 1'b0, 5'sd0, 1'b0, 4'h0);
    repeat (2) cyc();
    chk("rst_out_a", flat_a(), '0);
    chk1("rst_ready_a", ir_a, 1'b0);
    chk1("rst_valid_a", ov_a, 1'b0);
    chk("rst_out_b", flat_b(), '0);
    rst = 1'b0;
    cyc();

    // Main diagonal
    ew = '0;
    for (int i = 0; i < 8; i++) put(1'b0, i, i, 4'(i + 1));
    push(1'b0);
    v = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    run_frame(1'b0, 5'sd0, v, 8);

    // Super-diagonal k=+3
    ew = '0;
    put(1'b0, 0, 3, 4'hA); put(1'b0, 1, 4, 4'hB); put(1'b0, 2, 5, 4'hC);
    put(1'b0, 3, 6, 4'hD); put(1'b0, 4, 7, 4'hE);
    push(1'b0);
    v = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h0, 4'h0, 4'h0};
    run_frame(1'b0, 5'sd3, v, 5);

    // Corner k=-7, then empty k=8 and k=-8 (must also clear the previous F)
    ew = '0;
    put(1'b0, 7, 0, 4'hF);
    push(1'b0);
    v = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_frame(1'b0, -5'sd7, v, 1);
    ew = '0;
    push(1'b0);
    run_frame(1'b0, 5'sd8, v, 0);
    ew = '0;
    push(1'b0);
    run_frame(1'b0, -5'sd8, v, 0);

    // Backpressure: alternating stalls, start/offset noise, 4-cycle out_ready hold-off
    ew = '0;
    v = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h1};
    for (int i = 0; i < 8; i++) put(1'b0, i, i, v[i]);
    push(1'b0);
    ordy_a = 1'b0;
    drv(1'b0, 1'b1, 5'sd0, 1'b0, 4'h0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 1'b1, 5'sd5, 1'b0, 4'hE);
      cyc();
      drv(1'b0, 1'b0, 5'sd0, 1'b1, v[i]);
      cyc();
      if (i == 6) chk1("bp_not_early", ov_a, 1'b0);
    end
    chk1("bp_done_valid", ov_a, 1'b1);
    repeat (4) begin
      drv(1'b0, 1'b1, -5'sd3, 1'b1, 4'h6);
      cyc();
    end
    chk1("bp_hold_valid", ov_a, 1'b1);
    chk("bp_hold_out", flat_a(), ew);
    drv(1'b0, 1'b0, 5'sd0, 1'b0, 4'h0);
    ordy_a = 1'b1;
    cyc();
    chk1("bp_idle_valid", ov_a, 1'b0);
    chk1("bp_idle_ready", ir_a, 1'b0);

    // Reset after three beats, then a clean frame
    drv(1'b0, 1'b1, 5'sd0, 1'b0, 4'h0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 5'sd0, 1'b1, 4'(i + 1));
      cyc();
    end
    drv(1'b0, 1'b0, 5'sd0, 1'b0, 4'h0);
    rst = 1'b1;
    cyc();
    chk("midrst_out", flat_a(), '0);
    chk1("midrst_ready", ir_a, 1'b0);
    chk1("midrst_valid", ov_a, 1'b0);
    rst = 1'b0;
    cyc();
    ew = '0;
    v = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 8; i++) put(1'b0, i, i, v[i]);
    push(1'b0);
    run_frame(1'b0, 5'sd0, v, 8);

    // Non-square 4x6
    ew = '0;
    put(1'b1, 0, 2, 4'h1); put(1'b1, 1, 3, 4'h2); put(1'b1, 2, 4, 4'h3); put(1'b1, 3, 5, 4'h4);
    push(1'b1);
    v = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    run_frame(1'b1, 5'sd2, v, 4);
    ew = '0;
    put(1'b1, 1, 0, 4'h1); put(1'b1, 2, 1, 4'h2); put(1'b1, 3, 2, 4'h3);
    push(1'b1);
    run_frame(1'b1, -5'sd1, v, 3);

    repeat (3) cyc();
    chk1("sb_a_drained", exp_a.size() == 0, 1'b1);
    chk1("sb_b_drained", exp_b.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
